// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state codes, the
// per-stage control bundle and the normal-decode priority function.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic back_we;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;

  // Load-use wins over a taken branch: the branch operands are not valid yet,
  // so the branch is re-evaluated once the bubble has gone through.
  function automatic ctrl_t normal_decode(input logic lu, input logic branch);
    ctrl_t c;
    c = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, back_we: 1'b1};
    if (lu) begin
      c.pc_we       = 1'b0;
      c.ifid_we     = 1'b0;
      c.idex_bubble = 1'b1;
    end else if (branch) begin
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory request inputs and per-stage pipeline controls of the stall
// controller; the slave modport is the controller, master is its environment.
interface pipeline_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             hz_stall_i;
  logic             hz_pcwrite_i;
  logic             hz_noop_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_we_o;
  logic             ifid_we_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             back_we_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             err_o;

  modport master (
    output hz_stall_i, hz_pcwrite_i, hz_noop_i, branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o,
    input  stall_cnt_o, flush_cnt_o, err_o
  );

  modport slave (
    input  hz_stall_i, hz_pcwrite_i, hz_noop_i, branch_taken_i, mem_req_i, mem_ready_i,
    output pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o,
    output stall_cnt_o, flush_cnt_o, err_o
  );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (inc_i && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Load-use / memory-wait stall controller for a 5-stage pipeline, with
// stall/flush performance counters and a memory-wait timeout watchdog.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  ctrl_t             ctrl_norm, ctrl_next, ctrl_out;
  logic              lu;
  logic              stall_next;
  logic [1:0]        cnt_inc;
  logic [CNT_W-1:0]  cnt_val [2];

  // Any malformed combination of the three detector lines is a full stall.
  assign lu        = bus.hz_stall_i | bus.hz_noop_i | ~bus.hz_pcwrite_i;
  assign ctrl_norm = normal_decode(lu, bus.branch_taken_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_RUN;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    ctrl_next  = CTRL_FREEZE;
    stall_next = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (bus.mem_req_i && !bus.mem_ready_i) begin
          stall_next = 1'b1;
          state_next = ST_MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end else begin
          ctrl_next  = ctrl_norm;
          stall_next = lu;
        end
      end
      // The MEM stage is frozen here, so mem_req_i carries no new information.
      ST_MEM_WAIT: begin
        if (bus.mem_ready_i) begin
          ctrl_next  = ctrl_norm;
          stall_next = lu;
          state_next = ST_RUN;
          wait_next  = '0;
        end else if (wait_reg == WAIT_LAST) begin
          stall_next = 1'b1;
          state_next = ST_ERROR;
        end else begin
          stall_next = 1'b1;
          wait_next  = wait_reg + 1'b1;
        end
      end
      ST_ERROR: begin
        ctrl_next = CTRL_FREEZE;
      end
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Outputs go to freeze the moment reset asserts, without waiting for an edge.
  assign ctrl_out   = rst_i ? ctrl_next : CTRL_FREEZE;
  assign cnt_inc[0] = rst_i & stall_next;
  assign cnt_inc[1] = ctrl_out.ifid_flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (cnt_inc[gi]),
        .cnt_o (cnt_val[gi])
      );
    end
  endgenerate

  assign bus.pc_we_o       = ctrl_out.pc_we;
  assign bus.ifid_we_o     = ctrl_out.ifid_we;
  assign bus.ifid_flush_o  = ctrl_out.ifid_flush;
  assign bus.idex_bubble_o = ctrl_out.idex_bubble;
  assign bus.back_we_o     = ctrl_out.back_we;
  assign bus.stall_cnt_o   = cnt_val[0];
  assign bus.flush_cnt_o   = cnt_val[1];
  assign bus.err_o         = (state_reg == ST_ERROR);

endmodule
